// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared constants, line record, bus command and FSM state types for the data cache
package data_cache_pkg;
  localparam int XLEN = 32;
  localparam int DCACHE_LINES = 32;
  localparam int IDX_W = $clog2(DCACHE_LINES);
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [XLEN-9:0] tags;
    logic [63:0] data;
  } DCACHE_PACKET;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    FETCH_REQ,
    FETCH_WAIT,
    DONE
  } dcache_state_t;
endpackage

// File: rtl/data_cache.sv
// data_cache: blocking direct-mapped write-back write-allocate data cache; DCACHE_DEBUG_EN adds show_dcache_data
module data_cache
  import data_cache_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      Dmem2proc_response,
  input  logic [63:0]     Dmem2proc_data,
  input  logic [3:0]      Dmem2proc_tag,
  input  logic [XLEN-1:0] proc2Dcache_addr,
  input  logic [63:0]     proc2Dcache_data,
  input  logic [1:0]      proc2Dcache_command,
  output logic [1:0]      proc2Dmem_command,
  output logic [XLEN-1:0] proc2Dmem_addr,
  output logic [63:0]     proc2Dmem_data,
  output logic [63:0]     Dcache_data_out,
  output logic            Dcache_valid_out,
  output logic            finished
`ifdef DCACHE_DEBUG_EN
  ,
  output DCACHE_PACKET    show_dcache_data [DCACHE_LINES]
`endif
);
  DCACHE_PACKET lines [DCACHE_LINES];
  dcache_state_t state, next_state;
  logic [3:0] pend_tag;
  logic [63:0] rdata;
  logic done_load;
  logic [IDX_W-1:0] idx;
  logic [XLEN-9:0] tag;
  logic is_load, is_store, is_mem, hit, fill;

  assign idx = proc2Dcache_addr[7:3];
  assign tag = proc2Dcache_addr[XLEN-1:8];
  assign is_load = proc2Dcache_command == BUS_LOAD;
  assign is_store = proc2Dcache_command == BUS_STORE;
  assign is_mem = is_load || is_store;
  assign hit = lines[idx].valid && lines[idx].tags == tag;
  assign fill = pend_tag != 4'd0 && Dmem2proc_tag == pend_tag;

`ifdef DCACHE_DEBUG_EN
  assign show_dcache_data = lines;
`endif

  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;

  // next-state and bus/processor outputs decoded from the current state
  always_comb begin
    next_state = state;
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr = '0;
    proc2Dmem_data = '0;
    Dcache_data_out = '0;
    Dcache_valid_out = 1'b0;
    finished = 1'b0;
    case (state)
      IDLE:
        next_state = !is_mem || hit ? DONE
                   : lines[idx].valid && lines[idx].dirty ? WB_REQ : FETCH_REQ;
      WB_REQ: begin
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr = {lines[idx].tags, idx, 3'b0};
        proc2Dmem_data = lines[idx].data;
        next_state = Dmem2proc_response != 4'd0 ? FETCH_REQ : WB_REQ;
      end
      FETCH_REQ: begin
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr = {proc2Dcache_addr[XLEN-1:3], 3'b0};
        next_state = Dmem2proc_response != 4'd0 ? FETCH_WAIT : FETCH_REQ;
      end
      FETCH_WAIT:
        next_state = fill ? IDLE : FETCH_WAIT;
      DONE: begin
        finished = 1'b1;
        Dcache_valid_out = done_load;
        Dcache_data_out = done_load ? rdata : '0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // line array, pending memory tag and load result; the miss path returns to IDLE so the retry hits
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DCACHE_LINES; i++) lines[i] <= '0;
      pend_tag <= '0;
      rdata <= '0;
      done_load <= 1'b0;
    end else
      case (state)
        IDLE: begin
          done_load <= is_load;
          if (is_load && hit) rdata <= lines[idx].data;
          if (is_store && hit) begin
            lines[idx].data <= proc2Dcache_data;
            lines[idx].dirty <= 1'b1;
          end
        end
        WB_REQ:
          if (Dmem2proc_response != 4'd0) lines[idx].dirty <= 1'b0;
        FETCH_REQ:
          if (Dmem2proc_response != 4'd0) pend_tag <= Dmem2proc_response;
        FETCH_WAIT:
          if (fill) begin
            lines[idx] <= '{valid: 1'b1, dirty: 1'b0, tags: tag, data: Dmem2proc_data};
            pend_tag <= '0;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with hand-computed bus and result values
module tb_data_cache;
  import data_cache_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] Dmem2proc_response = '0, Dmem2proc_tag = '0;
  logic [63:0] Dmem2proc_data = '0, proc2Dcache_data = '0;
  logic [XLEN-1:0] proc2Dcache_addr = '0;
  logic [1:0] proc2Dcache_command = '0;
  logic [1:0] proc2Dmem_command;
  logic [XLEN-1:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data, Dcache_data_out;
  logic Dcache_valid_out, finished;
  int n_cmp = 0, n_bad = 0;

  data_cache dut (
    .clock(clock), .reset(reset),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag), .proc2Dcache_addr(proc2Dcache_addr),
    .proc2Dcache_data(proc2Dcache_data), .proc2Dcache_command(proc2Dcache_command),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data), .Dcache_data_out(Dcache_data_out),
    .Dcache_valid_out(Dcache_valid_out), .finished(finished)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus(input string name, input logic [1:0] cmd, input logic [XLEN-1:0] addr);
    check({name, ".cmd"}, 64'(proc2Dmem_command), 64'(cmd));
    check({name, ".addr"}, 64'(proc2Dmem_addr), 64'(addr));
  endtask

  task automatic done(input string name, input logic valid, input logic [63:0] data);
    check({name, ".fin"}, 64'(finished), 64'd1);
    check({name, ".vld"}, 64'(Dcache_valid_out), 64'(valid));
    if (valid) check({name, ".data"}, Dcache_data_out, data);
  endtask

  task automatic req(input logic [1:0] cmd, input logic [XLEN-1:0] addr, input logic [63:0] data = '0);
    proc2Dcache_command = cmd;
    proc2Dcache_addr = addr;
    proc2Dcache_data = data;
  endtask

  task automatic accept(input logic [3:0] resp);
    Dmem2proc_response = resp;
    step();
    Dmem2proc_response = '0;
  endtask

  task automatic reply(input logic [3:0] t, input logic [63:0] data);
    Dmem2proc_tag = t;
    Dmem2proc_data = data;
    step();
    Dmem2proc_tag = '0;
  endtask

  initial begin
    step();
    check("rst.fin", 64'(finished), 64'd0);
    check("rst.vld", 64'(Dcache_valid_out), 64'd0);
    bus("rst", BUS_NONE, '0);
    reset = 1'b0;
    // 1: cold load miss on addr 1 fetches block 0
    req(BUS_LOAD, 32'h1);
    step();
    bus("t1.fetch", BUS_LOAD, 32'h0);
    accept(4'd3);
    bus("t1.wait", BUS_NONE, '0);
    reply(4'd5, 64'hDEAD_DEAD_DEAD_DEAD);
    check("t1.badtag.fin", 64'(finished), 64'd0);
    bus("t1.badtag", BUS_NONE, '0);
    reply(4'd3, 64'h1111_2222_3333_4444);
    step();
    done("t1", 1'b1, 64'h1111_2222_3333_4444);
    // 2: store hit on line 0 makes it dirty without bus traffic
    req(BUS_STORE, 32'h3, 64'hA5A5);
    step();
    check("t2.gap", 64'(finished), 64'd0);
    bus("t2.idle", BUS_NONE, '0);
    step();
    done("t2", 1'b0, '0);
    bus("t2.done", BUS_NONE, '0);
    // 3: store miss to 0x100 writes back the dirty victim then allocates
    req(BUS_STORE, 32'h100, 64'h5A5A_0000);
    step(2);
    bus("t3.wb", BUS_STORE, 32'h0);
    check("t3.wb.data", proc2Dmem_data, 64'hA5A5);
    step();
    bus("t3.wbhold", BUS_STORE, 32'h0);
    accept(4'd1);
    bus("t3.fetch", BUS_LOAD, 32'h100);
    accept(4'd2);
    reply(4'd2, 64'hBEEF);
    step();
    done("t3", 1'b0, '0);
    // line 0 now holds tag 1 with the stored data
    req(BUS_LOAD, 32'h100);
    step(2);
    done("t3.hit", 1'b1, 64'h5A5A_0000);
    // evicting it must write back the dirty store data
    req(BUS_LOAD, 32'h0);
    step(2);
    bus("t3.evict", BUS_STORE, 32'h100);
    check("t3.evict.data", proc2Dmem_data, 64'h5A5A_0000);
    accept(4'd1);
    bus("t3.refetch", BUS_LOAD, 32'h0);
    accept(4'd6);
    reply(4'd6, 64'hCAFE);
    step();
    done("t3.reload", 1'b1, 64'hCAFE);
    // 4: NONE completes next cycle with no data and no bus traffic
    req(BUS_NONE, 32'h0);
    step(2);
    done("t4", 1'b0, '0);
    bus("t4", BUS_NONE, '0);
    // 5: load addr 8 is re-driven while memory declines
    req(BUS_LOAD, 32'h8);
    step(2);
    for (int i = 0; i < 3; i++) begin
      bus($sformatf("t5.retry%0d", i), BUS_LOAD, 32'h8);
      step();
    end
    accept(4'd4);
    reply(4'd7, 64'h7777);
    check("t5.mismatch.fin", 64'(finished), 64'd0);
    // 6: reset in FETCH_WAIT clears everything; the late reply is ignored
    reset = 1'b1;
    #1;
    bus("t6.rst", BUS_NONE, '0);
    check("t6.rst.fin", 64'(finished), 64'd0);
    check("t6.rst.vld", 64'(Dcache_valid_out), 64'd0);
    req(BUS_NONE, 32'h0);
    step();
    reset = 1'b0;
    reply(4'd4, 64'h4444);
    req(BUS_LOAD, 32'h8);
    step(2);
    bus("t6.miss8", BUS_LOAD, 32'h8);
    req(BUS_LOAD, 32'h1);
    accept(4'd0);
    accept(4'd0);
    req(BUS_NONE, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req(BUS_LOAD, 32'h1);
    step(2);
    bus("t6.miss0", BUS_LOAD, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
